// File: rtl/exec_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, write-back,
// with sticky halt on ebreak and sticky error on fetch timeout.
module exec_seq_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        dec_en,
  input  logic        ebreak,
  output logic        rf_we_en,
  output logic [63:0] pc,
  output logic [31:0] instret,
  output logic        halted,
  output logic        err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
  // A FETCH cycle without rvalid while the counter holds this value is the
  // 255th wait; the counter would reach 255, so the fetch is abandoned.
  localparam logic [7:0]  WAIT_LAST = 8'd254;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;

  // imem handshake: imem_req stays high with imem_addr stable for every
  // FETCH cycle; the first cycle that sees imem_rvalid high completes the
  // fetch and captures imem_rdata. rvalid has no meaning outside FETCH.

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_rvalid) begin
          state_nxt = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_ERR;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (ebreak) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB:    state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    dec_en    = 1'b0;
    rf_we_en  = 1'b0;
    halted    = 1'b0;
    err       = 1'b0;
    imem_addr = pc;
    dbg_state = state;
    case (state)
      S_FETCH:  imem_req = 1'b1;
      S_DECODE: dec_en   = 1'b1;
      S_WB:     rf_we_en = 1'b1;
      S_HALT:   halted   = 1'b1;
      S_ERR:    err      = 1'b1;
      default:  ;
    endcase
  end

  // Architectural state only moves on fetch capture, retirement and halt.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc       <= RESET_PC;
      inst     <= 32'd0;
      instret  <= 32'd0;
      wait_cnt <= 8'd0;
    end else begin
      if (state == S_FETCH && imem_rvalid) begin
        inst <= imem_rdata;
      end
      if (state == S_FETCH && !imem_rvalid) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
      if (state == S_WB) begin
        pc      <= pc + 64'd4;
        instret <= instret + 32'd1;
      end
      if (state == S_EXEC && ebreak) begin
        instret <= instret + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Randomized bench for exec_seq_ctrl: a transaction-level model tracks the
// expected pc, instret and latched instruction per fetched instruction.
module tb_exec_seq_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        dec_en;
  logic        ebreak;
  logic        rf_we_en;
  logic [63:0] pc;
  logic [31:0] instret;
  logic        halted;
  logic        err;
  logic [2:0]  dbg_state;

  exec_seq_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .dec_en      (dec_en),
    .ebreak      (ebreak),
    .rf_we_en    (rf_we_en),
    .pc          (pc),
    .instret     (instret),
    .halted      (halted),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [63:0] exp_pc;
  logic [31:0] exp_instret;
  logic [31:0] exp_inst;
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc      = RESET_PC;
    exp_instret = 32'd0;
    exp_inst    = 32'd0;
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},     imem_req, 0);
    check({tag, "_dec"},     dec_en, 0);
    check({tag, "_we"},      rf_we_en, 0);
    check({tag, "_halted"},  halted, 0);
    check({tag, "_err"},     err, 0);
    check({tag, "_pc"},      pc, RESET_PC);
    check({tag, "_instret"}, instret, 0);
    check({tag, "_inst"},    inst, 0);
  endtask

  // Reset with noisy inputs; they must all be overridden by rstn.
  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start       = 1'($urandom_range(0, 1));
      imem_rvalid = 1'($urandom_range(0, 1));
      ebreak      = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      @(negedge clk);
      check_idle_outputs("rst");
    end
    rstn        = 1'b1;
    start       = 1'b0;
    imem_rvalid = 1'b0;
    ebreak      = 1'b0;
    model_reset();
    @(negedge clk);
    check_idle_outputs("post_rst");
  endtask

  task automatic do_start();
    check("start_idle_req", imem_req, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_req", imem_req, 1);
    check("start_addr", imem_addr, exp_pc);
  endtask

  // Non-running states: random inputs must not disturb anything.
  task automatic sticky_noise(input int n, input bit exp_halted, input bit exp_err,
                              input bit allow_start);
    for (int i = 0; i < n; i++) begin
      start       = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rvalid = 1'($urandom_range(0, 1));
      ebreak      = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      @(negedge clk);
      check("noise_req", imem_req, 0);
      check("noise_dec", dec_en, 0);
      check("noise_we", rf_we_en, 0);
      check("noise_halted", halted, exp_halted);
      check("noise_err", err, exp_err);
      check("noise_pc", pc, exp_pc);
      check("noise_instret", instret, exp_instret);
      check("noise_inst", inst, exp_inst);
    end
    start       = 1'b0;
    imem_rvalid = 1'b0;
    ebreak      = 1'b0;
  endtask

  // One instruction from its first FETCH cycle; rvalid arrives after
  // 'delay' waiting cycles. Optionally halts in EXEC or resets in DECODE.
  task automatic run_instr(input int delay, input logic [31:0] data, input bit brk,
                           input bit rst_in_decode);
    exp_q.push_back(data);
    for (int k = 0; k <= delay; k++) begin
      check("fetch_req", imem_req, 1);
      check("fetch_addr", imem_addr, exp_pc);
      check("fetch_err", err, 0);
      imem_rvalid = (k == delay);
      imem_rdata  = (k == delay) ? data : $urandom;
      ebreak      = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    // DECODE
    exp_inst    = exp_q.pop_front();
    imem_rvalid = 1'($urandom_range(0, 1));
    imem_rdata  = $urandom;
    ebreak      = 1'($urandom_range(0, 1));
    check("dec_en", dec_en, 1);
    check("dec_inst", inst, exp_inst);
    check("dec_req", imem_req, 0);
    check("dec_we", rf_we_en, 0);
    if (rst_in_decode) begin
      rstn = 1'b0;
      @(negedge clk);
      model_reset();
      check_idle_outputs("rst_dec");
      rstn        = 1'b1;
      imem_rvalid = 1'b0;
      ebreak      = 1'b0;
      @(negedge clk);
      check_idle_outputs("rst_dec_rel");
      return;
    end
    @(negedge clk);
    // EXEC
    check("exec_dec", dec_en, 0);
    check("exec_we", rf_we_en, 0);
    check("exec_req", imem_req, 0);
    check("exec_pc", pc, exp_pc);
    ebreak      = brk;
    imem_rvalid = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (brk) begin
      exp_instret++;
      ebreak = 1'b0;
      check("halt_halted", halted, 1);
      check("halt_instret", instret, exp_instret);
      check("halt_pc", pc, exp_pc);
      check("halt_we", rf_we_en, 0);
      check("halt_req", imem_req, 0);
      return;
    end
    // WB
    check("wb_we", rf_we_en, 1);
    check("wb_halted", halted, 0);
    check("wb_pc", pc, exp_pc);
    check("wb_instret", instret, exp_instret);
    ebreak      = 1'($urandom_range(0, 1));
    imem_rvalid = 1'($urandom_range(0, 1));
    @(negedge clk);
    exp_pc      = exp_pc + 64'd4;
    exp_instret = exp_instret + 32'd1;
    imem_rvalid = 1'b0;
    check("refetch_req", imem_req, 1);
    check("refetch_pc", pc, exp_pc);
    check("refetch_instret", instret, exp_instret);
    check("refetch_we", rf_we_en, 0);
  endtask

  // FETCH with no rvalid for 255 cycles must end in ERR.
  task automatic run_timeout();
    for (int k = 0; k < 255; k++) begin
      check("to_req", imem_req, 1);
      check("to_err", err, 0);
      imem_rvalid = 1'b0;
      ebreak      = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ebreak = 1'b0;
    check("to_err_set", err, 1);
    check("to_req_drop", imem_req, 0);
    check("to_pc", pc, exp_pc);
    check("to_instret", instret, exp_instret);
    check("to_inst", inst, exp_inst);
  endtask

  initial begin
    rstn        = 1'b0;
    start       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    ebreak      = 1'b0;
    model_reset();
    @(negedge clk);

    // Directed: first instruction, delayed fetch, halt on third EXEC.
    do_reset();
    sticky_noise(5, 1'b0, 1'b0, 1'b0);
    do_start();
    run_instr(0, 32'h0010_0093, 1'b0, 1'b0);
    check("first_pc", pc, 64'h0000_0000_8000_0004);
    check("first_instret", instret, 32'd1);
    run_instr(10, $urandom, 1'b0, 1'b0);
    run_instr(0, $urandom, 1'b1, 1'b0);
    check("halt3_pc", pc, 64'h0000_0000_8000_0008);
    check("halt3_instret", instret, 32'd3);
    sticky_noise(8, 1'b1, 1'b0, 1'b1);

    // Random delays, then the 255th-cycle boundary and the timeout.
    do_reset();
    do_start();
    for (int i = 0; i < 20; i++) begin
      run_instr($urandom_range(0, 6), $urandom, 1'b0, 1'b0);
    end
    run_instr(254, $urandom, 1'b0, 1'b0);
    run_timeout();
    sticky_noise(8, 1'b0, 1'b1, 1'b1);

    // Reset while in DECODE after two retired instructions.
    do_reset();
    do_start();
    run_instr($urandom_range(0, 3), $urandom, 1'b0, 1'b0);
    run_instr($urandom_range(0, 3), $urandom, 1'b0, 1'b0);
    run_instr($urandom_range(0, 3), $urandom, 1'b0, 1'b1);
    sticky_noise(4, 1'b0, 1'b0, 1'b0);

    // Random program running until an ebreak.
    do_start();
    for (int i = 0; i < 30; i++) begin
      automatic bit brk = ($urandom_range(0, 7) == 0) || (i == 29);
      run_instr($urandom_range(0, 8), $urandom, brk, 1'b0);
      if (brk) break;
    end
    sticky_noise(6, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
